perceptron_layer: RTL

Parametrised successor to the single perceptron: a layer of M neurons sharing one N-element input vector. Each neuron has one signed MAC and accumulates over the N inputs in N cycles. The accumulated sum passes through a run-time selectable activation (step, ReLU, identity). Valid/ready handshakes on both sides replace the fixed enable-delay line, so layers can be chained with backpressure.

---
 rtl/perceptron_layer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/perceptron_layer.sv
// rtl/perceptron_layer.sv - layer of M signed-MAC neurons sharing one N-element input vector
// One MAC step per neuron per cycle, then saturate and apply the selected activation.
module perceptron_layer #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*N-1:0]     x,
  input  logic [W*N*M-1:0]   w,
  input  logic [W-1:0]       threshold,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*M-1:0]     y,
  output logic [M-1:0]       fire
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int NP = 1 << IW;

  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]            ONE  = W'(1 << FRAC);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                    state, state_nx;
  logic [IW-1:0]             cnt;
  logic                      flush;
  logic signed [W-1:0]       xr [NP];
  logic signed [W-1:0]       wr [M][NP];
  logic signed [W-1:0]       thr;
  logic [1:0]                moder;
  logic signed [ACC_W-1:0]   acc [M];
  logic signed [2*W-1:0]     prod [M];
  logic signed [ACC_W-1:0]   s [M];
  logic signed [W-1:0]       v [M];
  logic [W-1:0]              y_nx [M];
  logic [M-1:0]              fire_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // flush marks the extra cycle after the last MAC, used to register the activations
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ACCUM;
      end
      ACCUM: begin
        if (flush) state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    for (int m = 0; m < M; m++) begin
      prod[m] = (2*W)'(xr[cnt]) * (2*W)'(wr[m][cnt]);
      s[m]    = acc[m] >>> FRAC;
      if (s[m] > SMAX)      v[m] = SMAX[W-1:0];
      else if (s[m] < SMIN) v[m] = SMIN[W-1:0];
      else                  v[m] = s[m][W-1:0];
      fire_nx[m] = (v[m] >= thr);
      case (moder)
        2'd0:    y_nx[m] = fire_nx[m] ? ONE : '0;
        2'd1:    y_nx[m] = (v[m] < 0) ? '0 : v[m];
        default: y_nx[m] = v[m];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      flush <= 1'b0;
      thr   <= '0;
      moder <= '0;
      y     <= '0;
      fire  <= '0;
      for (int i = 0; i < NP; i++) xr[i] <= '0;
      for (int m = 0; m < M; m++) begin
        acc[m] <= '0;
        for (int i = 0; i < NP; i++) wr[m][i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            flush <= 1'b0;
            thr   <= threshold;
            moder <= mode;
            for (int i = 0; i < N; i++) xr[i] <= x[i*W +: W];
            for (int m = 0; m < M; m++) begin
              acc[m] <= '0;
              for (int i = 0; i < N; i++) wr[m][i] <= w[(m*N+i)*W +: W];
            end
          end
        end
        ACCUM: begin
          if (!flush) begin
            for (int m = 0; m < M; m++) acc[m] <= acc[m] + ACC_W'(prod[m]);
            if (cnt == IW'(N-1)) flush <= 1'b1;
            else                 cnt   <= cnt + 1'b1;
          end else begin
            fire <= fire_nx;
            for (int m = 0; m < M; m++) y[m*W +: W] <= y_nx[m];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
